// File: rtl/hps_pkg.sv
// Shared constants and types for the harmonic-product-spectrum stage and its pitch tracker.
// The upstream HPS stage uses the same bin count, offset and product width.
package hps_pkg;

    localparam int HPS_NUM_BINS      = 32;
    localparam int HPS_BIN_OFFSET    = 2;
    localparam int HPS_PRODUCT_WIDTH = 48;
    localparam int HPS_BEAT_WIDTH    = $clog2(HPS_NUM_BINS);

    typedef struct packed {
        logic       voiced;
        logic [8:0] reserved;
        logic [5:0] bin;
    } pitch_word_t;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DECIDE,
        ST_OUTPUT
    } tracker_state_t;

    // A 7-bit frame value is {voiced, bin}. It becomes the 16-bit pitch word.
    function automatic pitch_word_t encode_pitch(input logic [6:0] value);
        pitch_word_t word;
        word.voiced   = value[6];
        word.reserved = '0;
        word.bin      = value[5:0];
        return word;
    endfunction

endpackage

// File: rtl/pitch_hysteresis.sv
// Frame-count hysteresis on the 7-bit {voiced, bin} frame value.
// The reported value changes only after STABLE_FRAMES consecutive agreeing frames.
module pitch_hysteresis #(
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_update,
    input  logic [6:0] i_frame,
    output logic [6:0] o_current_next
);

    localparam logic [4:0] LP_STABLE = 5'(STABLE_FRAMES);

    logic [6:0] r_current;
    logic [6:0] r_candidate;
    logic [3:0] r_count;

    logic [6:0] w_candidate_next;
    logic [3:0] w_count_next;
    logic [4:0] w_count_inc;

    assign w_count_inc = {1'b0, r_count} + 5'd1;

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        o_current_next   = r_current;
        w_candidate_next = r_candidate;
        w_count_next     = r_count;
        if (i_update) begin
            if (i_frame == r_current) begin
                w_count_next = '0;
            end else if (i_frame == r_candidate) begin
                if (w_count_inc >= LP_STABLE) begin
                    o_current_next = i_frame;
                    w_count_next   = '0;
                end else begin
                    w_count_next = w_count_inc[3:0];
                end
            end else begin
                w_candidate_next = i_frame;
                if (STABLE_FRAMES == 1) begin
                    o_current_next = i_frame;
                    w_count_next   = '0;
                end else begin
                    w_count_next = 4'd1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_current   <= '0;
            r_candidate <= '0;
            r_count     <= '0;
        end else begin
            r_current   <= o_current_next;
            r_candidate <= w_candidate_next;
            r_count     <= w_count_next;
        end
    end

endmodule

// File: rtl/hps_pitch_tracker.sv
// Finds the argmax bin of each 32-beat HPS frame, applies the voicing threshold and hysteresis,
// and emits one pitch word per frame.
module hps_pitch_tracker
    import hps_pkg::*;
#(
    parameter logic [HPS_PRODUCT_WIDTH-1:0] THRESHOLD     = 48'h0000_0001_0000,
    parameter int                           STABLE_FRAMES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_hps_valid,
    output logic                         o_hps_ready,
    input  logic [HPS_PRODUCT_WIDTH-1:0] i_hps_data,
    output logic                         o_pitch_valid,
    input  logic                         i_pitch_ready,
    output logic [15:0]                  o_pitch_data
);

    tracker_state_t r_state;
    tracker_state_t w_state_next;

    logic [HPS_BEAT_WIDTH-1:0]    r_beat;
    logic [HPS_BEAT_WIDTH-1:0]    r_idx;
    logic [HPS_PRODUCT_WIDTH-1:0] r_max;
    pitch_word_t                  r_pitch;

    logic       w_accept;
    logic       w_decide;
    logic [5:0] w_bin;
    logic [6:0] w_frame;
    logic [6:0] w_current_next;

    assign w_accept = i_hps_valid && o_hps_ready;
    assign w_bin    = 6'(r_idx) + 6'(HPS_BIN_OFFSET);
    assign w_frame  = (r_max >= THRESHOLD) ? {1'b1, w_bin} : 7'd0;

    always_comb begin
        w_state_next  = r_state;
        o_hps_ready   = 1'b0;
        o_pitch_valid = 1'b0;
        w_decide      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                o_hps_ready = 1'b1;
                if (i_hps_valid && r_beat == HPS_BEAT_WIDTH'(HPS_NUM_BINS - 1)) begin
                    w_state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_decide     = 1'b1;
                w_state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                o_pitch_valid = 1'b1;
                if (i_pitch_ready) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // Beat 0 loads unconditionally; later beats win only when strictly greater, so ties keep the lowest bin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
            r_beat  <= '0;
            r_idx   <= '0;
            r_max   <= '0;
            r_pitch <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_beat <= r_beat + 1'b1;
                if (r_beat == '0 || i_hps_data > r_max) begin
                    r_max <= i_hps_data;
                    r_idx <= r_beat;
                end
            end
            if (w_decide) begin
                r_pitch <= encode_pitch(w_current_next);
            end
        end
    end

    pitch_hysteresis #(
        .STABLE_FRAMES(STABLE_FRAMES)
    ) u_hysteresis (
        .clk           (clk),
        .reset         (reset),
        .i_update      (w_decide),
        .i_frame       (w_frame),
        .o_current_next(w_current_next)
    );

    assign o_pitch_data = r_pitch;

endmodule

// File: tb/tb_hps_pitch_tracker.sv
// Directed bench for hps_pitch_tracker: framing, argmax, threshold, hysteresis, stalls and reset.
module tb_hps_pitch_tracker;

    localparam logic [47:0] T    = 48'h0000_0001_0000;
    localparam logic [47:0] T5   = 48'h0000_0005_0000;
    localparam logic [47:0] TM1  = 48'h0000_0000_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        hps_valid;
    logic        hps_ready;
    logic [47:0] hps_data;
    logic        pitch_valid;
    logic        pitch_ready;
    logic [15:0] pitch_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hps_pitch_tracker #(
        .THRESHOLD    (T),
        .STABLE_FRAMES(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_hps_valid  (hps_valid),
        .o_hps_ready  (hps_ready),
        .i_hps_data   (hps_data),
        .o_pitch_valid(pitch_valid),
        .i_pitch_ready(pitch_ready),
        .o_pitch_data (pitch_data)
    );

    task automatic check(input string tag, input logic [47:0] actual, input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic wait_hps_ready(input string tag);
        int n = 0;
        while (hps_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (hps_ready !== 1'b1) check({tag, " ready timeout"}, 48'(hps_ready), 48'd1);
    endtask

    task automatic send_beat(input string tag, input logic [47:0] data);
        wait_hps_ready(tag);
        hps_valid = 1'b1;
        hps_data  = data;
        @(negedge clk);
    endtask

    // Drives one frame (peak values at bin_a/bin_b, 1 elsewhere) and checks the resulting word.
    task automatic run_frame(input string tag, input int bin_a, input logic [47:0] val_a,
                             input int bin_b, input logic [47:0] val_b,
                             input int stall, input logic [15:0] exp_word);
        int n;
        for (int b = 0; b < 32; b++) begin
            logic [47:0] d;
            d = 48'd1;
            if (b + 2 == bin_a) d = val_a;
            if (b + 2 == bin_b) d = val_b;
            send_beat(tag, d);
        end
        hps_valid = (stall > 0);
        hps_data  = 48'd1;
        check({tag, " decide valid"}, 48'(pitch_valid), 48'd0);
        check({tag, " decide hps_ready"}, 48'(hps_ready), 48'd0);
        @(negedge clk);
        check({tag, " latency valid"}, 48'(pitch_valid), 48'd1);
        n = 0;
        while (pitch_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " word"}, 48'(pitch_data), 48'(exp_word));
        if (stall > 0) begin
            pitch_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, " stall valid"}, 48'(pitch_valid), 48'd1);
                check({tag, " stall hps_ready"}, 48'(hps_ready), 48'd0);
                check({tag, " stall word"}, 48'(pitch_data), 48'(exp_word));
            end
            pitch_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " valid drop"}, 48'(pitch_valid), 48'd0);
        check({tag, " hps_ready back"}, 48'(hps_ready), 48'd1);
    endtask

    initial begin
        reset       = 1'b1;
        hps_valid   = 1'b0;
        hps_data    = '0;
        pitch_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset pitch_valid", 48'(pitch_valid), 48'd0);
        check("reset pitch_data", 48'(pitch_data), 48'd0);
        check("reset hps_ready", 48'(hps_ready), 48'd1);
        reset = 1'b0;
        @(negedge clk);

        // Bin 9 becomes stable after three frames.
        run_frame("t1f1", 9, T5, 0, 0, 0, 16'h0000);
        run_frame("t1f2", 9, T5, 0, 0, 0, 16'h0000);
        run_frame("t1f3", 9, T5, 0, 0, 0, 16'h8009);

        // Two bin-12 frames do not switch; returning to bin 9 resets the count.
        for (int i = 0; i < 4; i++) run_frame("t2b9", 9, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b12a", 12, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b12b", 12, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b9r", 9, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b12c", 12, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b12d", 12, T5, 0, 0, 0, 16'h8009);
        run_frame("t2b12e", 12, T5, 0, 0, 0, 16'h800C);

        // Equal maxima at bins 5 and 20: lowest bin wins.
        run_frame("t3tie1", 5, T5, 20, T5, 0, 16'h800C);
        run_frame("t3tie2", 5, T5, 20, T5, 0, 16'h800C);
        run_frame("t3tie3", 5, T5, 20, T5, 0, 16'h8005);

        // Back to stable bin 9, then sub-threshold frames drop to unvoiced on the third.
        run_frame("t4b9a", 9, T5, 0, 0, 0, 16'h8005);
        run_frame("t4b9b", 9, T5, 0, 0, 0, 16'h8005);
        run_frame("t4b9c", 9, T5, 0, 0, 0, 16'h8009);
        run_frame("t4lo1", 9, TM1, 0, 0, 0, 16'h8009);
        run_frame("t4lo2", 9, TM1, 0, 0, 0, 16'h8009);
        run_frame("t4lo3", 9, TM1, 0, 0, 0, 16'h0000);

        // Output stalled 10 cycles with upstream valid; max exactly at threshold counts as voiced.
        run_frame("t5stall", 9, T, 0, 0, 10, 16'h0000);
        run_frame("t5f2", 9, T5, 0, 0, 0, 16'h0000);
        run_frame("t5f3", 9, T5, 0, 0, 0, 16'h8009);

        // Reset after 17 beats discards the partial frame and the hysteresis state.
        for (int b = 0; b < 17; b++) send_beat("t6part", (b == 3) ? T5 : 48'd1);
        hps_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6 post-reset valid", 48'(pitch_valid), 48'd0);
        check("t6 post-reset data", 48'(pitch_data), 48'd0);
        check("t6 post-reset hps_ready", 48'(hps_ready), 48'd1);
        run_frame("t6f1", 2, T5, 0, 0, 0, 16'h0000);
        run_frame("t6f2", 2, T5, 0, 0, 0, 16'h0000);
        run_frame("t6f3", 2, T5, 0, 0, 0, 16'h8002);

        // A strictly greater later bin replaces the earlier maximum.
        run_frame("t7gt1", 10, T5, 30, T5 + 48'd1, 0, 16'h8002);
        run_frame("t7gt2", 10, T5, 30, T5 + 48'd1, 0, 16'h8002);
        run_frame("t7gt3", 10, T5, 30, T5 + 48'd1, 0, 16'h801E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
